// File: rtl/me_dist_arbiter.sv
// rtl/me_dist_arbiter.sv - round-robin serialiser of PE distortions with best-match tracking
// One output register fed by a bypass-capable round-robin pick over pending slots and fresh pulses.
module me_dist_arbiter #(
  parameter int NPE   = 16,
  parameter int DW    = 16,
  parameter int NCAND = 256
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [NPE-1:0]    peready,
  input  logic [NPE*DW-1:0] pe_dist,
  input  logic [3:0]        vectory,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_dist,
  output logic [3:0]        out_vx,
  output logic [3:0]        out_vy,
  output logic [DW-1:0]     best_dist,
  output logic [3:0]        best_vx,
  output logic [3:0]        best_vy,
  output logic              done,
  output logic              overrun
);

  localparam int PW = $clog2(NPE);
  localparam int CW = $clog2(NCAND + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state;
  logic [NPE-1:0]  pending;
  logic [DW-1:0]   slot_dist [NPE];
  logic [3:0]      slot_vy   [NPE];
  logic [PW-1:0]   ptr;
  logic [CW-1:0]   count;

  logic            run_en, accept, load, gnt_any, ovr_hit, gi;
  logic [NPE-1:0]  cap, eff_pend, pend_n;
  logic [PW-1:0]   gidx, idx, ptr_n;
  logic [DW-1:0]   g_dist;
  logic [3:0]      g_vy;

  assign run_en   = start && (state != S_DONE);
  assign cap      = peready & {NPE{run_en}};
  assign eff_pend = pending | cap;
  assign accept   = out_valid && out_ready;
  assign load     = gnt_any && run_en && (!out_valid || accept);

  // Scan downwards so the last hit is the one closest to the pointer.
  always_comb begin
    gnt_any = 1'b0;
    gidx    = '0;
    idx     = '0;
    for (int k = NPE - 1; k >= 0; k--) begin
      idx = ptr + PW'(k);
      if (eff_pend[idx]) begin
        gnt_any = 1'b1;
        gidx    = idx;
      end
    end
  end

  assign ptr_n = PW'((int'(gidx) + 1) % NPE);

  // A stored slot wins over the fresh pulse, so a same-cycle repeat stays pending.
  always_comb begin
    g_dist = pending[gidx] ? slot_dist[gidx] : pe_dist[int'(gidx)*DW +: DW];
    g_vy   = pending[gidx] ? slot_vy[gidx]   : vectory;
  end

  always_comb begin
    pend_n  = pending;
    ovr_hit = 1'b0;
    gi      = 1'b0;
    for (int i = 0; i < NPE; i++) begin
      gi = load && (gidx == PW'(i));
      if (gi) pend_n[i] = 1'b0;
      if (cap[i]) begin
        if (pending[i] || !gi) pend_n[i] = 1'b1;
        if (pending[i] && !gi) ovr_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      pending   <= '0;
      ptr       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_dist  <= '0;
      out_vx    <= '0;
      out_vy    <= '0;
      best_dist <= '1;
      best_vx   <= '0;
      best_vy   <= '0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < NPE; i++) begin
        slot_dist[i] <= '0;
        slot_vy[i]   <= '0;
      end
    end else if (!start) begin
      state     <= S_IDLE;
      pending   <= '0;
      ptr       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_dist  <= '0;
      out_vx    <= '0;
      out_vy    <= '0;
      best_dist <= '1;
      best_vx   <= '0;
      best_vy   <= '0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < NPE; i++) begin
        slot_dist[i] <= '0;
        slot_vy[i]   <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: state <= S_RUN;
        S_RUN: begin
          if (accept && count == CW'(NCAND - 1)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        default: state <= S_DONE;
      endcase

      pending <= pend_n;
      overrun <= overrun | ovr_hit;
      for (int i = 0; i < NPE; i++) begin
        if (cap[i]) begin
          slot_dist[i] <= pe_dist[i*DW +: DW];
          slot_vy[i]   <= vectory;
        end
      end

      if (load) begin
        out_valid <= 1'b1;
        out_dist  <= g_dist;
        out_vx    <= 4'(gidx) - 4'd8;
        out_vy    <= g_vy;
        ptr       <= ptr_n;
      end else if (accept) begin
        out_valid <= 1'b0;
      end

      if (accept && state != S_DONE) begin
        count <= count + 1'b1;
        if (out_dist < best_dist) begin
          best_dist <= out_dist;
          best_vx   <= out_vx;
          best_vy   <= out_vy;
        end
      end
    end
  end

endmodule
